// File: rtl/capture_sequencer_if.sv
// capture_sequencer_if
//   Bundles the host command/status signals and the capture-block handshake
//   of capture_sequencer.
//   master : host/capture-block side (drives start/stop/cfg and capture flags)
//   slave  : the sequencer (drives cap_arm/cap_abort/cap_post_count and status)
//   With CAPTURE_SEQUENCER_PRETRIG_EN defined, cfg_min_pre is added.
interface capture_sequencer_if #(
    parameter int saddr_w = 24,
    parameter int rep_w   = 8,
    parameter int tmo_w   = 32
);
    logic               start;
    logic               stop;
    logic [saddr_w-1:0] cfg_post_count;
    logic [rep_w-1:0]   cfg_repeat;
    logic [tmo_w-1:0]   cfg_timeout;
`ifdef CAPTURE_SEQUENCER_PRETRIG_EN
    logic [saddr_w-1:0] cfg_min_pre;
`endif
    logic               cap_armed;
    logic               cap_triggered;
    logic               cap_overrun;
    logic               fifo_wr_beat;
    logic               cap_arm;
    logic               cap_abort;
    logic [saddr_w-1:0] cap_post_count;
    logic               busy;
    logic               done;
    logic               error;
    logic [1:0]         err_code;
    logic [rep_w-1:0]   caps_done;
    logic               irq;

    modport master (
        output start, stop, cfg_post_count, cfg_repeat, cfg_timeout,
        output cap_armed, cap_triggered, cap_overrun, fifo_wr_beat,
`ifdef CAPTURE_SEQUENCER_PRETRIG_EN
        output cfg_min_pre,
`endif
        input  cap_arm, cap_abort, cap_post_count, busy, done, error,
        input  err_code, caps_done, irq
    );

    modport slave (
        input  start, stop, cfg_post_count, cfg_repeat, cfg_timeout,
        input  cap_armed, cap_triggered, cap_overrun, fifo_wr_beat,
`ifdef CAPTURE_SEQUENCER_PRETRIG_EN
        input  cfg_min_pre,
`endif
        output cap_arm, cap_abort, cap_post_count, busy, done, error,
        output err_code, caps_done, irq
    );
endinterface

// File: rtl/capture_sequencer.sv
// capture_sequencer
//   Control-domain sequencer for the trigger capture datapath. A host start
//   latches the configuration, then runs cfg_repeat captures back to back:
//   arm the capture block, wait for the trigger, count post-trigger FIFO
//   beats, repeat. Overrun, trigger timeout or host stop abort the session
//   with a sticky error and err_code; every session end raises a 1-cycle irq.
//   Ports: clk, reset (async, active-high), bus (capture_sequencer_if.slave).
//   Option: CAPTURE_SEQUENCER_PRETRIG_EN adds cfg_min_pre; a trigger seen
//   before that many WAIT_TRIG beats is premature and aborts (err_code 3).
module capture_sequencer #(
    parameter int saddr_w = 24,
    parameter int rep_w   = 8,
    parameter int tmo_w   = 32
) (
    input  logic                clk,
    input  logic                reset,
    capture_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ARM, WAIT_ARMED, WAIT_TRIG, POST, NEXT, ABORT} state_t;

    state_t             state;
    logic               armed_s1, armed_sync;
    logic [saddr_w-1:0] post_q, post_rem;
    logic [rep_w-1:0]   rep_q, caps_done_q;
    logic [tmo_w-1:0]   tmo_q, tmo_cnt;
    logic [1:0]         ab_cnt;
    logic               cap_arm_q, cap_abort_q, busy_q, done_q, error_q, irq_q;
    logic [1:0]         err_code_q;
    logic               abort_req;
    logic [1:0]         abort_code;
`ifdef CAPTURE_SEQUENCER_PRETRIG_EN
    logic [saddr_w-1:0] min_pre_q, pre_cnt;
`endif

    // cap_armed comes from the sample clock domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_s1   <= 1'b0;
            armed_sync <= 1'b0;
        end else begin
            armed_s1   <= bus.cap_armed;
            armed_sync <= armed_s1;
        end
    end

    // Abort causes, highest priority first: stop > overrun > timeout > premature trigger
    always_comb begin
        abort_req  = 1'b0;
        abort_code = 2'd0;
        if (state != IDLE && state != ABORT) begin
            if (bus.stop) begin
                abort_req  = 1'b1;
                abort_code = 2'd3;
            end else if (bus.cap_overrun && (state == WAIT_TRIG || state == POST)) begin
                abort_req  = 1'b1;
                abort_code = 2'd1;
            end else if (state == WAIT_TRIG && tmo_q != '0 && (tmo_cnt + tmo_w'(1)) == tmo_q) begin
                abort_req  = 1'b1;
                abort_code = 2'd2;
`ifdef CAPTURE_SEQUENCER_PRETRIG_EN
            end else if (state == WAIT_TRIG && bus.cap_triggered && pre_cnt < min_pre_q) begin
                abort_req  = 1'b1;
                abort_code = 2'd3;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            post_q      <= '0;
            post_rem    <= '0;
            rep_q       <= '0;
            caps_done_q <= '0;
            tmo_q       <= '0;
            tmo_cnt     <= '0;
            ab_cnt      <= '0;
            cap_arm_q   <= 1'b0;
            cap_abort_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            irq_q       <= 1'b0;
            err_code_q  <= 2'd0;
`ifdef CAPTURE_SEQUENCER_PRETRIG_EN
            min_pre_q   <= '0;
            pre_cnt     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            irq_q  <= 1'b0;
            if (abort_req) begin
                // err_code is cleared on start and ABORT always ends the
                // session, so this is necessarily the first cause.
                state       <= ABORT;
                err_code_q  <= abort_code;
                cap_arm_q   <= 1'b0;
                cap_abort_q <= 1'b1;
                ab_cnt      <= '0;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        post_q      <= bus.cfg_post_count;
                        rep_q       <= (bus.cfg_repeat == '0) ? rep_w'(1) : bus.cfg_repeat;
                        tmo_q       <= bus.cfg_timeout;
`ifdef CAPTURE_SEQUENCER_PRETRIG_EN
                        min_pre_q   <= bus.cfg_min_pre;
`endif
                        error_q     <= 1'b0;
                        err_code_q  <= 2'd0;
                        caps_done_q <= '0;
                        busy_q      <= 1'b1;
                        cap_arm_q   <= 1'b1;
                        state       <= ARM;
                    end
                    ARM: if (armed_sync) begin
                        cap_arm_q <= 1'b0;
                        state     <= WAIT_ARMED;
                    end
                    // armed dropping or triggered rising means the block has
                    // moved on, including a trigger that fired while arming
                    WAIT_ARMED: if (!armed_sync || bus.cap_triggered) begin
                        tmo_cnt <= '0;
`ifdef CAPTURE_SEQUENCER_PRETRIG_EN
                        pre_cnt <= '0;
`endif
                        state   <= WAIT_TRIG;
                    end
                    WAIT_TRIG: begin
                        tmo_cnt <= tmo_cnt + tmo_w'(1);
`ifdef CAPTURE_SEQUENCER_PRETRIG_EN
                        if (bus.fifo_wr_beat && pre_cnt != '1)
                            pre_cnt <= pre_cnt + saddr_w'(1);
`endif
                        if (bus.cap_triggered) begin
                            post_rem <= post_q;
                            state    <= POST;
                        end
                    end
                    POST: begin
                        if (post_rem == '0 && !bus.cap_triggered)
                            state <= NEXT;
                        else if (bus.fifo_wr_beat && post_rem != '0)
                            post_rem <= post_rem - saddr_w'(1);
                    end
                    NEXT: begin
                        caps_done_q <= caps_done_q + rep_w'(1);
                        if ((caps_done_q + rep_w'(1)) == rep_q) begin
                            done_q <= 1'b1;
                            irq_q  <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            cap_arm_q <= 1'b1;
                            state     <= ARM;
                        end
                    end
                    ABORT: begin
                        // abort stays up at least 4 cycles and until the
                        // capture block has fully disarmed
                        if (ab_cnt == 2'd3 && !armed_sync && !bus.cap_triggered) begin
                            cap_abort_q <= 1'b0;
                            error_q     <= 1'b1;
                            irq_q       <= 1'b1;
                            busy_q      <= 1'b0;
                            state       <= IDLE;
                        end else if (ab_cnt != 2'd3) begin
                            ab_cnt <= ab_cnt + 2'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.cap_arm        = cap_arm_q;
    assign bus.cap_abort      = cap_abort_q;
    assign bus.cap_post_count = post_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.error          = error_q;
    assign bus.err_code       = err_code_q;
    assign bus.caps_done      = caps_done_q;
    assign bus.irq            = irq_q;
endmodule
